// File: rtl/laser_controller.sv
// laser_controller: launches a single laser pixel from the rocket position and steps it up the screen.
// Each step draws, waits a tick, erases, then moves. A kill request can end the flight early.
`default_nettype none

module laser_controller #(
  parameter int         TICK_DIV     = 833333,
  parameter logic [2:0] LASER_COLOUR = 3'b111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       fire,
  input  logic [7:0] rocketx,
  input  logic [6:0] rockety,
  input  logic       destroy_laser,
  output logic [7:0] laser_x,
  output logic [6:0] laser_y,
  output logic       laser_active,
  output logic       laser_move_done,
  output logic       laser_destroyed,
  output logic       plot,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [2:0] plot_colour
);

  localparam logic [19:0] C_TICK_LAST = 20'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAW  = 3'd1,
    S_WAIT  = 3'd2,
    S_ERASE = 3'd3,
    S_MOVE  = 3'd4,
    S_DONE  = 3'd5,
    S_KILL  = 3'd6
  } state_t;

  state_t      r_state, w_state_next;
  logic [19:0] r_tick, w_tick_next;
  logic        r_kill_pending, w_kill_pending_next;
  logic        r_fire_q;
  logic [7:0]  r_laser_x, w_laser_x_next;
  logic [6:0]  r_laser_y, w_laser_y_next;
  logic        w_launch;

  // Rising edge of the fire button only, so a held button cannot relaunch.
  assign w_launch = fire & ~r_fire_q & enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_tick         <= 20'd0;
      r_kill_pending <= 1'b0;
      r_fire_q       <= 1'b0;
      r_laser_x      <= 8'd0;
      r_laser_y      <= 7'd0;
    end else begin
      r_state        <= w_state_next;
      r_tick         <= w_tick_next;
      r_kill_pending <= w_kill_pending_next;
      r_fire_q       <= fire;
      r_laser_x      <= w_laser_x_next;
      r_laser_y      <= w_laser_y_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_tick_next         = r_tick;
    w_kill_pending_next = r_kill_pending;
    w_laser_x_next      = r_laser_x;
    w_laser_y_next      = r_laser_y;
    laser_active        = 1'b0;
    laser_move_done     = 1'b0;
    laser_destroyed     = 1'b0;
    plot                = 1'b0;
    plot_colour         = 3'd0;

    case (r_state)
      S_IDLE: begin
        w_kill_pending_next = 1'b0;
        if (w_launch) begin
          if (rockety != 7'd0) begin
            w_laser_x_next = rocketx;
            w_laser_y_next = rockety - 7'd1;
            w_state_next   = S_DRAW;
          end else begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DRAW: begin
        laser_active = 1'b1;
        plot         = 1'b1;
        plot_colour  = LASER_COLOUR;
        w_tick_next  = 20'd0;
        if (destroy_laser) w_kill_pending_next = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        laser_active = 1'b1;
        w_tick_next  = r_tick + 20'd1;
        // A kill, fresh or deferred, beats the step tick.
        if (destroy_laser || r_kill_pending) begin
          w_kill_pending_next = 1'b0;
          w_state_next        = S_KILL;
        end else if (r_tick == C_TICK_LAST) begin
          w_state_next = S_ERASE;
        end
      end
      S_ERASE: begin
        laser_active = 1'b1;
        plot         = 1'b1;
        if (r_laser_y == 7'd0) begin
          w_kill_pending_next = 1'b0;
          w_state_next        = S_DONE;
        end else begin
          if (destroy_laser) w_kill_pending_next = 1'b1;
          w_state_next = S_MOVE;
        end
      end
      S_MOVE: begin
        laser_active   = 1'b1;
        w_laser_y_next = r_laser_y - 7'd1;
        if (destroy_laser) w_kill_pending_next = 1'b1;
        w_state_next   = S_DRAW;
      end
      S_DONE: begin
        laser_move_done = 1'b1;
        w_state_next    = S_IDLE;
      end
      S_KILL: begin
        laser_active        = 1'b1;
        plot                = 1'b1;
        laser_destroyed     = 1'b1;
        w_kill_pending_next = 1'b0;
        w_state_next        = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign laser_x = r_laser_x;
  assign laser_y = r_laser_y;
  assign plot_x  = r_laser_x;
  assign plot_y  = r_laser_y;

endmodule

`default_nettype wire

// File: tb/tb_laser_controller.sv
// Bench for laser_controller: a flight-timeline model checked every cycle, plus literal scenario checks.
`default_nettype none

module tb_laser_controller;

  localparam int TICK = 4;

  localparam logic [2:0] K_IDLE  = 3'd0;
  localparam logic [2:0] K_DRAW  = 3'd1;
  localparam logic [2:0] K_WAIT  = 3'd2;
  localparam logic [2:0] K_ERASE = 3'd3;
  localparam logic [2:0] K_MOVE  = 3'd4;
  localparam logic [2:0] K_DONE  = 3'd5;
  localparam logic [2:0] K_KILL  = 3'd6;

  logic       clock, reset, enable, fire, destroy_laser;
  logic [7:0] rocketx;
  logic [6:0] rockety;
  logic [7:0] laser_x, plot_x;
  logic [6:0] laser_y, plot_y;
  logic       laser_active, laser_move_done, laser_destroyed, plot;
  logic [2:0] plot_colour;

  laser_controller #(.TICK_DIV(TICK), .LASER_COLOUR(3'b111)) dut (
    .clock(clock), .reset(reset), .enable(enable), .fire(fire),
    .rocketx(rocketx), .rockety(rockety), .destroy_laser(destroy_laser),
    .laser_x(laser_x), .laser_y(laser_y), .laser_active(laser_active),
    .laser_move_done(laser_move_done), .laser_destroyed(laser_destroyed),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: on launch the whole flight is laid out as a timeline of per-cycle activities.
  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] x;
    logic [6:0] y;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  bit   fire_prev, pending, mvalid;

  function automatic ent_t mk(input logic [2:0] k, input logic [7:0] x, input logic [6:0] y);
    ent_t e;
    e.kind = k; e.x = x; e.y = y;
    return e;
  endfunction

  task automatic model_step();
    if (reset) begin
      q.delete();
      cur = mk(K_IDLE, 8'd0, 7'd0);
      fire_prev = 0; pending = 0; mvalid = 1;
    end else begin
      case (cur.kind)
        K_IDLE: if (fire && !fire_prev && enable) begin
          if (rockety != 7'd0) begin
            for (int yy = int'(rockety) - 1; yy >= 0; yy--) begin
              q.push_back(mk(K_DRAW, rocketx, 7'(yy)));
              for (int t = 0; t < TICK; t++) q.push_back(mk(K_WAIT, rocketx, 7'(yy)));
              q.push_back(mk(K_ERASE, rocketx, 7'(yy)));
              q.push_back(mk((yy > 0) ? K_MOVE : K_DONE, rocketx, 7'(yy)));
            end
          end else begin
            q.push_back(mk(K_DONE, cur.x, cur.y));
          end
        end
        K_WAIT: if (destroy_laser || pending) begin
          q.delete();
          q.push_back(mk(K_KILL, cur.x, cur.y));
          pending = 0;
        end
        K_DRAW, K_MOVE: if (destroy_laser) pending = 1;
        K_ERASE: if (cur.y == 7'd0) pending = 0; else if (destroy_laser) pending = 1;
        K_KILL: pending = 0;
        default: ;
      endcase
      fire_prev = fire;
      if (q.size() > 0) cur = q.pop_front();
      else cur = mk(K_IDLE, cur.x, cur.y);
    end
  endtask

  initial begin
    mvalid = 0;
    cur = mk(K_IDLE, 8'd0, 7'd0);
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  int cnt_active, cnt_plot, cnt_done, cnt_destr;

  initial begin
    forever begin
      @(negedge clock);
      if (mvalid) begin
        logic e_act, e_plot;
        e_act  = (cur.kind == K_DRAW) || (cur.kind == K_WAIT) || (cur.kind == K_ERASE) ||
                 (cur.kind == K_MOVE) || (cur.kind == K_KILL);
        e_plot = (cur.kind == K_DRAW) || (cur.kind == K_ERASE) || (cur.kind == K_KILL);
        chk("laser_active", 32'(laser_active), 32'(e_act));
        chk("plot", 32'(plot), 32'(e_plot));
        chk("laser_move_done", 32'(laser_move_done), 32'(cur.kind == K_DONE));
        chk("laser_destroyed", 32'(laser_destroyed), 32'(cur.kind == K_KILL));
        chk("laser_x", 32'(laser_x), 32'(cur.x));
        chk("laser_y", 32'(laser_y), 32'(cur.y));
        if (e_plot) begin
          chk("plot_x", 32'(plot_x), 32'(cur.x));
          chk("plot_y", 32'(plot_y), 32'(cur.y));
          chk("plot_colour", 32'(plot_colour), (cur.kind == K_DRAW) ? 32'd7 : 32'd0);
        end
      end
      cnt_active += int'(laser_active);
      cnt_plot   += int'(plot);
      cnt_done   += int'(laser_move_done);
      cnt_destr  += int'(laser_destroyed);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic clr();
    cnt_active = 0; cnt_plot = 0; cnt_done = 0; cnt_destr = 0;
  endtask

  task automatic launch(input logic [7:0] x, input logic [6:0] y);
    rocketx = x; rockety = y; fire = 1'b1;
    step();
    fire = 1'b0;
  endtask

  task automatic counts(input string tag, input int a, input int p, input int d, input int k);
    chk({tag, "_active_cycles"}, 32'(cnt_active), 32'(a));
    chk({tag, "_plot_cycles"}, 32'(cnt_plot), 32'(p));
    chk({tag, "_done_pulses"}, 32'(cnt_done), 32'(d));
    chk({tag, "_destroyed_pulses"}, 32'(cnt_destr), 32'(k));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; fire = 1'b0; destroy_laser = 1'b0;
    rocketx = 8'd0; rockety = 7'd0;
    clr();
    step(3);
    chk("reset_active", 32'(laser_active), 32'd0);
    chk("reset_laser_x", 32'(laser_x), 32'd0);
    reset = 1'b0;
    step(2);

    // Normal flight from y=3: plots at y=2,1,0.
    clr();
    launch(8'd80, 7'd3);
    chk("normal_draw_plot", 32'(plot), 32'd1);
    chk("normal_draw_x", 32'(plot_x), 32'd80);
    chk("normal_draw_y", 32'(plot_y), 32'd2);
    chk("normal_draw_colour", 32'(plot_colour), 32'd7);
    step(5);
    chk("normal_erase_colour", 32'(plot_colour), 32'd0);
    chk("normal_erase_y", 32'(plot_y), 32'd2);
    step(2);
    chk("normal_draw2_y", 32'(plot_y), 32'd1);
    chk("normal_draw2_colour", 32'(plot_colour), 32'd7);
    step(22);
    counts("normal", 20, 6, 1, 0);
    chk("normal_final_y", 32'(laser_y), 32'd0);

    // Kill during WAIT at y=50.
    clr();
    launch(8'd20, 7'd51);
    step();
    destroy_laser = 1'b1;
    step();
    destroy_laser = 1'b0;
    chk("kill_plot", 32'(plot), 32'd1);
    chk("kill_colour", 32'(plot_colour), 32'd0);
    chk("kill_y", 32'(plot_y), 32'd50);
    chk("kill_destroyed", 32'(laser_destroyed), 32'd1);
    step(10);
    counts("kill", 3, 2, 0, 1);

    // Kill requested in MOVE is deferred to the next WAIT.
    clr();
    launch(8'd5, 7'd10);
    step(6);
    destroy_laser = 1'b1;
    step();
    destroy_laser = 1'b0;
    chk("pend_redraw_y", 32'(plot_y), 32'd8);
    step(10);
    counts("pending", 10, 4, 0, 1);
    chk("pending_final_y", 32'(laser_y), 32'd8);

    // Fire held high launches once only.
    clr();
    rocketx = 8'd7; rockety = 7'd2; fire = 1'b1;
    step(50);
    fire = 1'b0;
    step(2);
    counts("held", 13, 4, 1, 0);

    // Fire re-pulsed mid-flight is dropped.
    clr();
    launch(8'd7, 7'd2);
    step(3);
    fire = 1'b1;
    step();
    fire = 1'b0;
    step(20);
    counts("repulse", 13, 4, 1, 0);

    // Launch from the top row: no plot, immediate done.
    clr();
    launch(8'd9, 7'd0);
    chk("top_done", 32'(laser_move_done), 32'd1);
    chk("top_x_held", 32'(laser_x), 32'd7);
    step(5);
    counts("top", 0, 0, 1, 0);

    // Disabled: fire edges and idle kill requests do nothing.
    clr();
    enable = 1'b0;
    launch(8'd9, 7'd3);
    step(3);
    launch(8'd9, 7'd3);
    destroy_laser = 1'b1;
    step();
    destroy_laser = 1'b0;
    step(10);
    counts("disabled", 0, 0, 0, 0);
    enable = 1'b1;

    // Reset mid-flight abandons the laser silently.
    clr();
    launch(8'd40, 7'd5);
    step();
    reset = 1'b1;
    step();
    chk("rst_active", 32'(laser_active), 32'd0);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_laser_x", 32'(laser_x), 32'd0);
    chk("rst_laser_y", 32'(laser_y), 32'd0);
    reset = 1'b0;
    step(5);
    counts("midreset", 2, 1, 0, 0);

    // Recovery flight after reset.
    clr();
    launch(8'd3, 7'd1);
    step(10);
    counts("recover", 6, 2, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
